// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and fault codes for the MEM-stage access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_TIMEOUT = 2'b01;
    localparam logic [1:0] FLT_BUSERR  = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL = 2'b11;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating up-counter that flags when a memory wait has run too long.
module mem_timeout_counter #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: sequences one load/store against a ready-handshake
// memory, stalls the pipeline front and traps faults until reset.
//
// state | meaning
// IDLE  | no transaction; a single load/store request is latched and issued
// WAIT  | memReq held, waiting for memReady or timeout
// DONE  | transaction complete for one cycle; pipeline advances
// FAULT | sticky trap (timeout, bus error, illegal request) until reset
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic [31:0] inAddr,
    input  logic [31:0] inWriteData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memReady,
    input  logic        memErr,
    input  logic [31:0] memRData,
    output logic        outStall,
    output logic        outWbValid,
    output logic [31:0] outReadData,
    output logic        outFault,
    output logic [1:0]  outFaultCode
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  code_q, code_d;
    logic        cnt_clear, cnt_en, cnt_expired;

    mem_timeout_counter #(
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        code_d     = code_q;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        outStall   = 1'b0;
        outWbValid = 1'b1;
        case (state_q)
            IDLE: begin
                if (inMemRead && inMemWrite) begin
                    outStall   = 1'b1;
                    outWbValid = 1'b0;
                    code_d     = FLT_ILLEGAL;
                    state_d    = FAULT;
                end else if (inMemRead || inMemWrite) begin
                    outStall   = 1'b1;
                    outWbValid = 1'b0;
                    addr_d     = inAddr;
                    wdata_d    = inWriteData;
                    we_d       = inMemWrite;
                    cnt_clear  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                outStall   = 1'b1;
                outWbValid = 1'b0;
                cnt_en     = 1'b1;
                // A completion in the same cycle as expiry takes priority.
                if (memReady) begin
                    if (memErr) begin
                        code_d  = FLT_BUSERR;
                        state_d = FAULT;
                    end else begin
                        if (!we_q) rdata_d = memRData;
                        state_d = DONE;
                    end
                end else if (cnt_expired) begin
                    code_d  = FLT_TIMEOUT;
                    state_d = FAULT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                outStall   = 1'b1;
                outWbValid = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
        end
    end

    // Decoded from the state flop so reset removes the request immediately.
    assign memReq       = (state_q == WAIT);
    assign outFault     = (state_q == FAULT);
    assign memWe        = we_q;
    assign memAddr      = addr_q;
    assign memWData     = wdata_q;
    assign outReadData  = rdata_q;
    assign outFaultCode = code_q;

endmodule
